aa_window_gen: RTL

Streaming neighbourhood generator that feeds the anti-aliasing stage.
- Accepts one pixel per cycle in raster order.
- Buffers the two previous lines.
- Emits, for every interior pixel, the centre value plus its four cross neighbours (N, S, E, W) with coordinates. The AA stage's threshold test and averaging then need no frame-sized random access.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) are never emitted.

---
 rtl/aa_window_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/aa_window_gen.sv
`default_nettype none
// ============================================================================
// aa_window_gen : raster-stream cross-neighbourhood (C,N,S,E,W) generator
//                 feeding the anti-aliasing stage; border pixels suppressed.
// Revision      : 1.0
// ============================================================================
module aa_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c,
  output logic [DATA_W-1:0] out_n,
  output logic [DATA_W-1:0] out_s,
  output logic [DATA_W-1:0] out_w,
  output logic [DATA_W-1:0] out_e,
  output logic [9:0]        out_row,
  output logic [9:0]        out_col,
  output logic              out_last,
  output logic              frame_done
);

  localparam int         AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
  localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);

  logic [DATA_W-1:0] line1 [IMG_W];  // row r-1
  logic [DATA_W-1:0] line2 [IMG_W];  // row r-2

  logic [9:0]        wr_row;
  logic [9:0]        wr_col;
  logic [9:0]        cur_row;
  logic [9:0]        cur_col;
  logic [AW-1:0]     addr;
  logic              accept;
  logic              emit;
  logic [DATA_W-1:0] above1;
  logic [DATA_W-1:0] above2;
  logic [DATA_W-1:0] top_d1;
  logic [DATA_W-1:0] mid_d1;
  logic [DATA_W-1:0] mid_d2;
  logic [DATA_W-1:0] bot_d1;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Start-of-frame overrides the counters for the pixel that carries it.
  assign cur_row = in_sof ? 10'd0 : wr_row;
  assign cur_col = in_sof ? 10'd0 : wr_col;
  assign addr    = cur_col[AW-1:0];
  assign above1  = line1[addr];
  assign above2  = line2[addr];
  assign emit    = accept && (cur_row >= 10'd2) && (cur_col >= 10'd2);

  always_ff @(posedge clk) begin
    if (accept) begin
      line1[addr] <= in_pixel;
      line2[addr] <= above1;
    end
  end

  // Column-delayed copies of the three rows; only accepts shift them, so
  // bubbles never disturb the neighbourhood.
  always_ff @(posedge clk) begin
    if (accept) begin
      top_d1 <= above2;
      mid_d1 <= above1;
      mid_d2 <= mid_d1;
      bot_d1 <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (emit) begin
      out_c   <= mid_d1;
      out_n   <= top_d1;
      out_s   <= bot_d1;
      out_w   <= mid_d2;
      out_e   <= above1;
      out_row <= cur_row - 10'd1;
      out_col <= cur_col - 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_row     <= 10'd0;
      wr_col     <= 10'd0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;

      if (accept) begin
        if (cur_col == LAST_COL) begin
          wr_col <= 10'd0;
          wr_row <= (cur_row == LAST_ROW) ? 10'd0 : cur_row + 10'd1;
        end else begin
          wr_col <= cur_col + 10'd1;
          wr_row <= cur_row;
        end
      end

      // The final window of a frame is the one loaded by the final pixel.
      if (emit) begin
        out_valid <= 1'b1;
        out_last  <= (cur_row == LAST_ROW) && (cur_col == LAST_COL);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
